// File: rtl/addsub_pkg.sv
// Shared encodings for the sequential add/subtract unit.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package addsub_pkg;

    // Operation select, sampled together with Start.
    // Bit 0 selects subtract, bit 1 selects the accumulator as first operand.
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    // Control FSM states.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // True when the operation subtracts B.
    function automatic logic op_is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_ACC_SUB);
    endfunction

    // True when the first operand comes from the accumulator.
    function automatic logic op_uses_acc(input op_e op);
        return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the carry chain: sum, carry out, and carry into the slice MSB.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module addsub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    input  logic             inv_y,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK-1:0] y_eff;
    logic [CHUNK:0]   full;

    // Subtraction is x + ~y + 1; the +1 arrives through cin on the first slice.
    assign y_eff = inv_y ? ~y : y;

    // Full-width sum with the carry out kept in the extra bit.
    assign full = {1'b0, x} + {1'b0, y_eff} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];

    // Carry into the top bit; XOR with cout gives signed overflow on the last slice.
    generate
        if (CHUNK == 1) begin : g_single_bit
            assign msb_cin = cin;
        end else begin : g_multi_bit
            logic [CHUNK-1:0] low;
            assign low     = {1'b0, x[CHUNK-2:0]} + {1'b0, y_eff[CHUNK-2:0]}
                           + {{(CHUNK-1){1'b0}}, cin};
            assign msb_cin = low[CHUNK-1];
        end
    endgenerate

endmodule

// File: rtl/addsub_seq_unit.sv
// Multi-cycle WIDTH-bit add/subtract with accumulator, CHUNK bits per cycle, LSB first.
// Latency: NCHUNK cycles from accepted Start to the Done pulse; next Start allowed in the Done cycle.
// Backpressure: Busy=1 while running; Start and AccClr are ignored until Busy drops.
module addsub_seq_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             AccClr,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic [WIDTH-1:0] Acc
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // A width that does not split into whole chunks would silently drop the top bits.
    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
            $error("addsub_seq_unit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e          state;
    op_e             op_q;
    logic [IDXW-1:0] idx;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] r_sh;
    logic             cy_q;

    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic [WIDTH-1:0] r_nxt;
    logic [CHUNK-1:0] sum;
    logic             c_out;
    logic             c_msb;

    // The single shared slice always works on the low chunk of the operand shifters.
    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x       (x_sh[CHUNK-1:0]),
        .y       (y_sh[CHUNK-1:0]),
        .cin     (cy_q),
        .inv_y   (op_is_sub(op_q)),
        .sum     (sum),
        .cout    (c_out),
        .msb_cin (c_msb)
    );

    // Operands shift right one chunk per cycle; sum chunks enter the result from the top,
    // so after NCHUNK cycles the result register holds the whole word in order.
    generate
        if (NCHUNK == 1) begin : g_one_chunk
            assign x_nxt = '0;
            assign y_nxt = '0;
            assign r_nxt = sum;
        end else begin : g_many_chunks
            assign x_nxt = {{CHUNK{1'b0}}, x_sh[WIDTH-1:CHUNK]};
            assign y_nxt = {{CHUNK{1'b0}}, y_sh[WIDTH-1:CHUNK]};
            assign r_nxt = {sum, r_sh[WIDTH-1:CHUNK]};
        end
    endgenerate

    // Control FSM plus datapath registers; every output is a flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            idx      <= '0;
            x_sh     <= '0;
            y_sh     <= '0;
            r_sh     <= '0;
            cy_q     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Out      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b1;
            Acc      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        // Accumulator snapshot taken here; AccClr cannot reach it while busy.
                        x_sh  <= op_uses_acc(op_e'(Op)) ? Acc : A;
                        y_sh  <= B;
                        op_q  <= op_e'(Op);
                        idx   <= '0;
                        cy_q  <= op_is_sub(op_e'(Op));
                        state <= S_RUN;
                        Busy  <= 1'b1;
                    end else if (AccClr) begin
                        Acc <= '0;
                    end
                end
                S_RUN: begin
                    x_sh <= x_nxt;
                    y_sh <= y_nxt;
                    r_sh <= r_nxt;
                    cy_q <= c_out;
                    idx  <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state    <= S_IDLE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Out      <= r_nxt;
                        Carry    <= c_out;
                        // Carry into MSB differing from carry out is exactly signed overflow.
                        Overflow <= c_out ^ c_msb;
                        Zero     <= (r_nxt == '0);
                        if (op_uses_acc(op_q)) begin
                            Acc <= r_nxt;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Self-checking bench for addsub_seq_unit: scoreboard on the 64/16 instance, direct checks on 64/64 and 32/8.
// Latency: checks NCHUNK cycles from Start sample edge to Done.
// Backpressure: Start only issued when the unit should be idle, except deliberate ignored-Start probes.
module tb_addsub_seq_unit;

    localparam int N0 = 4;   // 64 / 16

    typedef struct {
        logic [63:0] out;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic [63:0] acc;
        int          start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    // Main instance 64/16
    logic        u0_start = 1'b0, u0_accclr = 1'b0;
    logic [1:0]  u0_op = 2'b00;
    logic [63:0] u0_a = '0, u0_b = '0;
    logic        u0_busy, u0_done, u0_carry, u0_ovf, u0_zero;
    logic [63:0] u0_out, u0_acc;

    // Single-chunk instance 64/64
    logic        s1_start = 1'b0, s1_accclr = 1'b0;
    logic [1:0]  s1_op = 2'b00;
    logic [63:0] s1_a = '0, s1_b = '0;
    logic        s1_busy, s1_done, s1_carry, s1_ovf, s1_zero;
    logic [63:0] s1_out, s1_acc;

    // Narrow instance 32/8
    logic        s2_start = 1'b0, s2_accclr = 1'b0;
    logic [1:0]  s2_op = 2'b00;
    logic [31:0] s2_a = '0, s2_b = '0;
    logic        s2_busy, s2_done, s2_carry, s2_ovf, s2_zero;
    logic [31:0] s2_out, s2_acc;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] m_acc = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pushed = 0;
    int          n_done = 0;

    addsub_seq_unit #(.WIDTH(64), .CHUNK(16)) u0 (
        .Clk(clk), .Reset(rst), .Start(u0_start), .Op(u0_op), .A(u0_a), .B(u0_b),
        .AccClr(u0_accclr), .Busy(u0_busy), .Done(u0_done), .Out(u0_out),
        .Carry(u0_carry), .Overflow(u0_ovf), .Zero(u0_zero), .Acc(u0_acc)
    );

    addsub_seq_unit #(.WIDTH(64), .CHUNK(64)) u1 (
        .Clk(clk), .Reset(rst), .Start(s1_start), .Op(s1_op), .A(s1_a), .B(s1_b),
        .AccClr(s1_accclr), .Busy(s1_busy), .Done(s1_done), .Out(s1_out),
        .Carry(s1_carry), .Overflow(s1_ovf), .Zero(s1_zero), .Acc(s1_acc)
    );

    addsub_seq_unit #(.WIDTH(32), .CHUNK(8)) u2 (
        .Clk(clk), .Reset(rst), .Start(s2_start), .Op(s2_op), .A(s2_a), .B(s2_b),
        .AccClr(s2_accclr), .Busy(s2_busy), .Done(s2_done), .Out(s2_out),
        .Carry(s2_carry), .Overflow(s2_ovf), .Zero(s2_zero), .Acc(s2_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: 65-bit arithmetic, overflow from operand/result sign bits.
    function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] acc_in, input int sc);
        exp_t        e;
        logic [63:0] x;
        logic [64:0] s;
        x = op[1] ? acc_in : a;
        if (op[0]) s = {1'b0, x} + {1'b0, ~b} + 65'd1;
        else       s = {1'b0, x} + {1'b0, b};
        e.out   = s[63:0];
        e.carry = s[64];
        if (op[0]) e.ovf = (x[63] != b[63]) && (e.out[63] != x[63]);
        else       e.ovf = (x[63] == b[63]) && (e.out[63] != x[63]);
        e.zero  = (e.out == 64'd0);
        e.acc   = op[1] ? e.out : acc_in;
        e.start_cyc = sc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle Start pulse; returns just after the sampling edge.
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input bit push);
        exp_t e;
        u0_op = op; u0_a = a; u0_b = b; u0_start = 1'b1;
        if (push) begin
            e = model(op, a, b, m_acc, cyc + 1);
            m_acc = e.acc;
            sb.push_back(e);
            n_pushed++;
        end
        tick();
        u0_start = 1'b0;
        check("busy_after_start", 64'(u0_busy), 64'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: compares every Done of the main instance.
    always @(negedge clk) begin
        if (u0_done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 64'(u0_done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out",      u0_out,          mon_e.out);
                check("carry",    64'(u0_carry),   64'(mon_e.carry));
                check("overflow", 64'(u0_ovf),     64'(mon_e.ovf));
                check("zero",     64'(u0_zero),    64'(mon_e.zero));
                check("acc",      u0_acc,          mon_e.acc);
                check("latency",  64'(cyc - mon_e.start_cyc), 64'(N0));
                check("busy_in_done", 64'(u0_busy), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [1:0]  rop;
        logic [63:0] ra, rb;
        exp_t        e;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy",  64'(u0_busy),  64'd0);
        check("rst_done",  64'(u0_done),  64'd0);
        check("rst_out",   u0_out,        64'd0);
        check("rst_acc",   u0_acc,        64'd0);
        check("rst_zero",  64'(u0_zero),  64'd1);
        check("rst_carry", 64'(u0_carry), 64'd0);
        check("rst_ovf",   64'(u0_ovf),   64'd0);

        // Directed add/sub cases
        issue(2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1);
        wait_drain();
        check("add_out_const", u0_out, 64'h0000_0001_0000_0000);
        issue(2'b01, 64'd0, 64'd1, 1'b1);
        wait_drain();
        issue(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        wait_drain();
        check("sub_ovf_const", 64'(u0_ovf), 64'd1);

        // Accumulate: clear, three back-to-back +5, then -20
        u0_accclr = 1'b1;
        tick();
        u0_accclr = 1'b0;
        m_acc = '0;
        check("accclr", u0_acc, 64'd0);
        for (int i = 0; i < 3; i++) begin
            issue(2'b10, 64'(i) * 64'hDEAD_BEEF, 64'd5, 1'b1);
            repeat (N0) tick();
        end
        issue(2'b11, 64'h1234, 64'd20, 1'b1);
        wait_drain();
        check("acc_final", u0_acc, 64'hFFFF_FFFF_FFFF_FFFB);

        // AccClr with Start and during Busy is ignored
        u0_accclr = 1'b1;
        issue(2'b00, 64'd1, 64'd2, 1'b1);
        repeat (N0 - 1) tick();
        u0_accclr = 1'b0;
        wait_drain();
        check("acc_kept", u0_acc, 64'hFFFF_FFFF_FFFF_FFFB);

        // Start held high: accepted at first edge and again in the Done cycle;
        // operands changed while busy must not leak into the first op.
        u0_op = 2'b00; u0_a = 64'h1111; u0_b = 64'h2222; u0_start = 1'b1;
        e = model(2'b00, 64'h1111, 64'h2222, m_acc, cyc + 1);
        sb.push_back(e); n_pushed++;
        e = model(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, m_acc, cyc + 1 + N0 + 1);
        sb.push_back(e); n_pushed++;
        tick();
        u0_a = 64'h7FFF_FFFF_FFFF_FFFF; u0_b = 64'd1;
        repeat (9) tick();
        u0_start = 1'b0;
        wait_drain();

        // Start pulse while busy produces no extra operation
        issue(2'b01, 64'd100, 64'd200, 1'b1);
        tick();
        u0_start = 1'b1; u0_a = 64'd5; u0_b = 64'd5;
        tick();
        u0_start = 1'b0;
        wait_drain();
        repeat (3 * N0) tick();
        check("done_count_mid", 64'(n_done), 64'(n_pushed));

        // Random ops, back-to-back or with gaps
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            rb  = (i % 4 == 0) ? ra : {$urandom, $urandom};
            issue(rop, ra, rb, 1'b1);
            repeat (N0) tick();
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain();

        // Reset during chunk 2 of an accumulate op aborts it
        issue(2'b10, 64'd0, 64'h123, 1'b1);
        wait_drain();
        issue(2'b10, 64'd0, 64'd5, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 64'(u0_busy), 64'd0);
        check("mid_rst_done", 64'(u0_done), 64'd0);
        check("mid_rst_out",  u0_out,       64'd0);
        check("mid_rst_acc",  u0_acc,       64'd0);
        check("mid_rst_zero", 64'(u0_zero), 64'd1);
        rst = 1'b0;
        m_acc = '0;
        repeat (3 * N0) tick();
        check("done_count_end", 64'(n_done), 64'(n_pushed));

        // WIDTH=64, CHUNK=64: one-cycle run
        s1_a = 64'h7FFF_FFFF_FFFF_FFFF; s1_b = 64'h7FFF_FFFF_FFFF_FFFF; s1_op = 2'b00; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        lat = 0;
        while (!s1_done && lat < 50) begin tick(); lat++; end
        check("w64c64_latency", 64'(lat), 64'd1);
        check("w64c64_out",     s1_out, 64'hFFFF_FFFF_FFFF_FFFE);
        check("w64c64_ovf",     64'(s1_ovf), 64'd1);
        check("w64c64_carry",   64'(s1_carry), 64'd0);

        // WIDTH=32, CHUNK=8: wrap to zero
        s2_a = 32'hFFFF_FFFF; s2_b = 32'd1; s2_op = 2'b00; s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        lat = 0;
        while (!s2_done && lat < 50) begin tick(); lat++; end
        check("w32c8_latency", 64'(lat), 64'd4);
        check("w32c8_out",     64'(s2_out), 64'd0);
        check("w32c8_carry",   64'(s2_carry), 64'd1);
        check("w32c8_zero",    64'(s2_zero), 64'd1);
        check("w32c8_ovf",     64'(s2_ovf), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
